// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory bus between the fetch sequencer and imem.
// Master drives ce/req/addr; slave answers with ack/rdata.
interface pc_fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              imem_ce_o;
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_ack_i;
  logic [31:0]       imem_rdata_i;

  modport master (
    output imem_ce_o,
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_ce_o,
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the imem req/ack handshake.
// Optional exception redirect and epc_o under `PC_EXC_EN.
module pc_fetch_ctrl #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 'h0000_0000,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = 'h0000_0020
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              branch_valid_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  pc_fetch_ctrl_if.master   imem,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [31:0]       if_inst_o
`ifdef PC_EXC_EN
  ,
  input  logic              exc_req_i,
  output logic [ADDR_W-1:0] epc_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t            st_q, st_d;
  logic              ce_q, ce_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [31:0]       inst_q, inst_d;
  logic              pnd_q, pnd_d;
  logic [ADDR_W-1:0] ptgt_q, ptgt_d;
  logic [ADDR_W-1:0] hpc_q, hpc_d;
  logic [31:0]       hinst_q, hinst_d;

  logic              exc_now;
  logic              redir;
  logic [ADDR_W-1:0] rtgt;

`ifdef PC_EXC_EN
  logic [ADDR_W-1:0] epc_q, epc_d;
  assign exc_now = exc_req_i;
  assign epc_o   = epc_q;
`else
  assign exc_now = 1'b0;
`endif

  // exception wins over a same-cycle branch
  assign redir = exc_now | branch_valid_i;
  assign rtgt  = exc_now ? EXC_VECTOR
                         : (branch_target_i & ~ADDR_W'(3));

  always_comb begin
    st_d    = st_q;
    ce_d    = ce_q;
    req_d   = req_q;
    addr_d  = addr_q;
    vld_d   = 1'b0;
    ipc_d   = ipc_q;
    inst_d  = inst_q;
    pnd_d   = pnd_q;
    ptgt_d  = ptgt_q;
    hpc_d   = hpc_q;
    hinst_d = hinst_q;
`ifdef PC_EXC_EN
    epc_d   = epc_q;
    if (exc_now) begin
      unique case (st_q)
        IDLE:    epc_d = RESET_VECTOR;
        HOLD:    epc_d = hpc_q;
        default: epc_d = addr_q;
      endcase
    end
`endif
    if (redir) begin
      pnd_d  = 1'b1;
      ptgt_d = rtgt;
    end
    unique case (st_q)
      IDLE: begin
        ce_d   = 1'b1;
        req_d  = 1'b1;
        addr_d = RESET_VECTOR;
        st_d   = FETCH;
      end
      FETCH: begin
        if (imem.imem_ack_i) begin
          if (pnd_q || redir) begin
            // stale fetch: drop it, restart at latest target
            addr_d = redir ? rtgt : ptgt_q;
            pnd_d  = 1'b0;
          end else if (!stall_i) begin
            vld_d  = 1'b1;
            ipc_d  = addr_q;
            inst_d = imem.imem_rdata_i;
            addr_d = addr_q + ADDR_W'(4);
          end else begin
            hpc_d   = addr_q;
            hinst_d = imem.imem_rdata_i;
            req_d   = 1'b0;
            st_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (redir) begin
          addr_d = rtgt;
          req_d  = 1'b1;
          pnd_d  = 1'b0;
          st_d   = FETCH;
        end else if (!stall_i) begin
          vld_d  = 1'b1;
          ipc_d  = hpc_q;
          inst_d = hinst_q;
          req_d  = 1'b1;
          addr_d = hpc_q + ADDR_W'(4);
          st_d   = FETCH;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      st_q    <= IDLE;
      ce_q    <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      ipc_q   <= '0;
      inst_q  <= '0;
      pnd_q   <= 1'b0;
      ptgt_q  <= '0;
      hpc_q   <= '0;
      hinst_q <= '0;
`ifdef PC_EXC_EN
      epc_q   <= '0;
`endif
    end else begin
      st_q    <= st_d;
      ce_q    <= ce_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      ipc_q   <= ipc_d;
      inst_q  <= inst_d;
      pnd_q   <= pnd_d;
      ptgt_q  <= ptgt_d;
      hpc_q   <= hpc_d;
      hinst_q <= hinst_d;
`ifdef PC_EXC_EN
      epc_q   <= epc_d;
`endif
    end
  end

  assign imem.imem_ce_o   = ce_q;
  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = addr_q;
  assign if_valid_o       = vld_q;
  assign if_pc_o          = ipc_q;
  assign if_inst_o        = inst_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed steps plus random traffic
// checked against an instruction-stream reference model.
module tb_pc_fetch_ctrl;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_valid_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        ack = 1'b0;
  logic        if_valid_o;
  logic [31:0] if_pc_o, if_inst_o;
  logic        wv;
  logic [31:0] wpc, winst;

  int          total = 0;
  int          bad = 0;
  int          ndeliv = 0;
  logic [31:0] exp_pc = 32'h0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  pc_fetch_ctrl_if #(.ADDR_W(32)) bus ();
  pc_fetch_ctrl_if #(.ADDR_W(32)) wbus ();
  assign bus.imem_ack_i    = ack;
  assign bus.imem_rdata_i  = mem(bus.imem_addr_o);
  assign wbus.imem_ack_i   = 1'b1;
  assign wbus.imem_rdata_i = mem(wbus.imem_addr_o);

`ifdef PC_EXC_EN
  logic        exc_req_i = 1'b0;
  logic [31:0] epc_o, wepc;
`endif

  pc_fetch_ctrl #(.ADDR_W(32)) dut (
    .clock(clock),
    .reset(reset),
    .stall_i(stall_i),
    .branch_valid_i(branch_valid_i),
    .branch_target_i(branch_target_i),
    .imem(bus),
    .if_valid_o(if_valid_o),
    .if_pc_o(if_pc_o),
    .if_inst_o(if_inst_o)
`ifdef PC_EXC_EN
    ,
    .exc_req_i(exc_req_i),
    .epc_o(epc_o)
`endif
  );

  pc_fetch_ctrl #(
    .ADDR_W(32),
    .RESET_VECTOR(32'hFFFF_FFFC)
  ) wdut (
    .clock(clock),
    .reset(reset),
    .stall_i(1'b0),
    .branch_valid_i(1'b0),
    .branch_target_i(32'h0),
    .imem(wbus),
    .if_valid_o(wv),
    .if_pc_o(wpc),
    .if_inst_o(winst)
`ifdef PC_EXC_EN
    ,
    .exc_req_i(1'b0),
    .epc_o(wepc)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; afterwards check protocol and the delivered stream.
  task automatic cyc();
    logic        preq, pack, prst, pstall;
    logic [31:0] paddr;
    preq   = bus.imem_req_o;
    paddr  = bus.imem_addr_o;
    pack   = ack;
    prst   = reset;
    pstall = stall_i;
    if (!reset) exp_pc = 32'h0;
`ifdef PC_EXC_EN
    else if (exc_req_i) exp_pc = 32'h20;
`endif
    else if (branch_valid_i) exp_pc = branch_target_i & ~32'd3;
    @(posedge clock);
    #1;
    branch_valid_i = 1'b0;
`ifdef PC_EXC_EN
    exc_req_i = 1'b0;
`endif
    if (!prst) begin
      chk("rst_req", {31'b0, bus.imem_req_o}, 32'h0);
      chk("rst_ce", {31'b0, bus.imem_ce_o}, 32'h0);
      chk("rst_addr", bus.imem_addr_o, 32'h0);
      chk("rst_valid", {31'b0, if_valid_o}, 32'h0);
      chk("rst_pc", if_pc_o, 32'h0);
      chk("rst_inst", if_inst_o, 32'h0);
    end else begin
      if (preq && !pack) begin
        chk("req_hold", {31'b0, bus.imem_req_o}, 32'h1);
        chk("addr_hold", bus.imem_addr_o, paddr);
      end
      if (pstall) chk("stall_quiet", {31'b0, if_valid_o}, 32'h0);
      if (if_valid_o) begin
        chk("if_pc", if_pc_o, exp_pc);
        chk("if_inst", if_inst_o, mem(if_pc_o));
        exp_pc = if_pc_o + 32'd4;
        ndeliv++;
      end
    end
  endtask

  task automatic until_addr(input logic [31:0] a);
    for (int i = 0; i < 64 && bus.imem_addr_o !== a; i++) cyc();
    chk("reach_addr", bus.imem_addr_o, a);
  endtask

  initial begin
    int d0;
    // reset held 3 cycles with ack tied high, then back-to-back fetch
    ack = 1'b1;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    chk("first_req", {31'b0, bus.imem_req_o}, 32'h1);
    chk("first_addr", bus.imem_addr_o, 32'h0);
    chk("first_novalid", {31'b0, if_valid_o}, 32'h0);
    chk("w_first_addr", wbus.imem_addr_o, 32'hFFFF_FFFC);
    cyc();
    chk("first_deliv", {31'b0, if_valid_o}, 32'h1);
    chk("first_pc", if_pc_o, 32'h0);
    chk("w_pc0", wpc, 32'hFFFF_FFFC);
    cyc();
    chk("w_wrap_valid", {31'b0, wv}, 32'h1);
    chk("w_wrap_pc", wpc, 32'h0);
    chk("w_wrap_inst", winst, mem(32'h0));
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("b2b_valid", {31'b0, if_valid_o}, 32'h1);
    end

    // stall at the ack of 0x8
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    until_addr(32'h8);
    stall_i = 1'b1;
    cyc();
    chk("stall_req", {31'b0, bus.imem_req_o}, 32'h0);
    repeat (3) cyc();
    chk("stall_req_end", {31'b0, bus.imem_req_o}, 32'h0);
    stall_i = 1'b0;
    cyc();
    chk("rel_valid", {31'b0, if_valid_o}, 32'h1);
    chk("rel_pc", if_pc_o, 32'h8);
    chk("rel_addr", bus.imem_addr_o, 32'hC);
    chk("rel_req", {31'b0, bus.imem_req_o}, 32'h1);
    cyc();
    chk("rel_next_pc", if_pc_o, 32'hC);

    // ack delayed 3 cycles per fetch
    ack = 1'b0;
    d0 = ndeliv;
    for (int k = 0; k < 6; k++) begin
      ack = 1'b0;
      repeat (3) cyc();
      ack = 1'b1;
      cyc();
    end
    chk("one_per_ack", ndeliv - d0, 32'd6);

    // branch during a 2-wait fetch of 0x10, then latest-wins
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    until_addr(32'h10);
    ack = 1'b0;
    branch_valid_i = 1'b1;
    branch_target_i = 32'h103;
    cyc();
    cyc();
    ack = 1'b1;
    cyc();
    chk("squash_valid", {31'b0, if_valid_o}, 32'h0);
    chk("redir_addr", bus.imem_addr_o, 32'h100);
    cyc();
    chk("br_pc", if_pc_o, 32'h100);
    ack = 1'b0;
    branch_valid_i = 1'b1;
    branch_target_i = 32'h200;
    cyc();
    branch_valid_i = 1'b1;
    branch_target_i = 32'h306;
    cyc();
    cyc();
    ack = 1'b1;
    cyc();
    chk("latest_addr", bus.imem_addr_o, 32'h304);
    chk("latest_squash", {31'b0, if_valid_o}, 32'h0);
    cyc();
    chk("latest_pc", if_pc_o, 32'h304);

    // reset mid-wait restarts at the reset vector
    ack = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    chk("restart_req", {31'b0, bus.imem_req_o}, 32'h1);
    chk("restart_addr", bus.imem_addr_o, 32'h0);
    ack = 1'b1;
    cyc();
    chk("restart_pc", if_pc_o, 32'h0);

`ifdef PC_EXC_EN
    until_addr(32'h40);
    ack = 1'b0;
    exc_req_i = 1'b1;
    branch_valid_i = 1'b1;
    branch_target_i = 32'h80;
    cyc();
    chk("epc", epc_o, 32'h40);
    ack = 1'b1;
    cyc();
    chk("exc_addr", bus.imem_addr_o, 32'h20);
    chk("exc_squash", {31'b0, if_valid_o}, 32'h0);
    cyc();
    chk("exc_pc", if_pc_o, 32'h20);
`endif

    // random traffic against the stream model
    d0 = ndeliv;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 250) != 0;
      ack = ($urandom % 3) != 0;
      stall_i = ($urandom % 5) == 0;
      if (($urandom % 20) == 0) begin
        branch_valid_i = 1'b1;
        branch_target_i = $urandom;
      end
      cyc();
    end
    chk("progress", {31'b0, (ndeliv - d0) > 300}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
